// File: rtl/dmem_responder_pkg.sv
// cpu_control_package: shared load/store encodings and dmem responder state type
package cpu_control_package;
  localparam logic [2:0] FUNCT3_LW = 3'b010;
  localparam logic [2:0] FUNCT3_SW = 3'b010;
  localparam logic [2:0] WORD_FUNCT3 = FUNCT3_LW;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channels between core memory stage and data memory
interface dmem_responder_if #(parameter int ADDR_W = 12);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [2:0] req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM, one write enable, registered read with sync clear
module dmem_ram #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // store port
  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;
  // read register; clear forces the zero result for stores, errors and reset
  always_ff @(posedge clk)
    rdata <= clr ? '0 : (en && !we) ? mem[addr] : rdata;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency LW/SW responder over internal RAM (option DMEM_ALIGN_CHECK_EN)
module dmem_responder
  import cpu_control_package::*;
#(
  parameter int LATENCY = 1,
  parameter int ADDR_W = 12
) (
  input logic clk,
  input logic reset,
  dmem_responder_if.slave bus
);
  localparam int WA = ADDR_W - 2;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  dmem_state_t state;
  logic [CW-1:0] cnt;
  logic we_q;
  logic [WA-1:0] wa_q;
  logic [31:0] wd_q;
  logic bad;
  logic access;
`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] lo_q;
  logic [2:0] f3_q;
  assign bad = lo_q != 2'b00 || f3_q != WORD_FUNCT3;
  // byte offset and funct3 are only kept when they are checked
  always_ff @(posedge clk)
    if (state == IDLE && bus.req_valid) {lo_q, f3_q} <= {bus.req_addr[1:0], bus.req_funct3};
`else
  assign bad = 1'b0;
`endif
  assign access = state == WAIT && cnt == '0 && !reset;
  // request/latency/response sequencing with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q <= bus.req_we;
          wa_q <= bus.req_addr[ADDR_W-1:2];
          wd_q <= bus.req_wdata;
          cnt <= CW'(LATENCY - 1);
          bus.req_ready <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err <= bad;
          state <= RESP;
        end else cnt <= cnt - CW'(1);
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  dmem_ram #(.DEPTH(1 << WA)) u_ram (
    .clk(clk),
    .clr(reset || (access && (we_q || bad))),
    .en(access && !bad),
    .we(we_q),
    .addr(wa_q),
    .wdata(wd_q),
    .rdata(bus.rsp_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for LATENCY=1 and LATENCY=4 responders
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic sel = 1'b0, rv = 1'b0, we = 1'b0, rr = 1'b0;
  logic [2:0] f3 = 3'b010;
  logic [11:0] addr = '0;
  logic [31:0] wd = '0;
  dmem_responder_if #(.ADDR_W(12)) i1 ();
  dmem_responder_if #(.ADDR_W(12)) i4 ();
  dmem_responder #(.LATENCY(1), .ADDR_W(12)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
  dmem_responder #(.LATENCY(4), .ADDR_W(12)) u4 (.clk(clk), .reset(reset), .bus(i4.slave));
  assign i1.req_valid = rv & ~sel;
  assign i4.req_valid = rv & sel;
  assign i1.rsp_ready = rr & ~sel;
  assign i4.rsp_ready = rr & sel;
  assign {i1.req_we, i1.req_funct3, i1.req_addr, i1.req_wdata} = {we, f3, addr, wd};
  assign {i4.req_we, i4.req_funct3, i4.req_addr, i4.req_wdata} = {we, f3, addr, wd};
  logic rdy, vld, err;
  logic [31:0] rdat;
  assign rdy = sel ? i4.req_ready : i1.req_ready;
  assign vld = sel ? i4.rsp_valid : i1.rsp_valid;
  assign err = sel ? i4.rsp_err : i1.rsp_err;
  assign rdat = sel ? i4.rsp_rdata : i1.rsp_rdata;
  int checks = 0, fails = 0;
  logic [32:0] q_exp [$];
  logic [31:0] mm [int];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!reset && vld && rr) begin
      chk("sb_nonempty", q_exp.size() > 0, 1);
      if (q_exp.size() > 0) begin
        logic [32:0] e;
        e = q_exp.pop_front();
        chk("rsp_rdata", rdat, e[31:0]);
        chk("rsp_err", err, e[32]);
      end
    end
  task automatic push(input logic w, input logic [2:0] f, input logic [11:0] a, input logic [31:0] d);
    logic e;
    int key;
`ifdef DMEM_ALIGN_CHECK_EN
    e = a[1:0] != 2'b00 || f != 3'b010;
`else
    e = 1'b0;
`endif
    key = int'({sel, a[11:2]});
    if (w && !e) mm[key] = d;
    q_exp.push_back({e, (w || e) ? 32'h0 : mm[key]});
  endtask
  task automatic xact(input logic w, input logic [2:0] f, input logic [11:0] a, input logic [31:0] d, input int stall);
    int lat, k;
    push(w, f, a, d);
    @(posedge clk); #1;
    {we, f3, addr, wd, rv, rr} = {w, f, a, d, 1'b1, stall == 0};
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (rdy) break;
      k++;
    end
    chk("accept_bound", k < 20, 1);
    @(posedge clk); #1;
    rv = 1'b0;
    we = 1'($urandom);
    addr = 12'($urandom);
    wd = $urandom;
    lat = 0;
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      if (vld) break;
      chk("ready_in_wait", rdy, 0);
      @(posedge clk);
      lat++;
      k++;
    end
    chk("latency", lat, sel ? 4 : 1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", vld, 1);
      chk("stall_ready", rdy, 0);
      if (q_exp.size() > 0) chk("stall_data", rdat, q_exp[0][31:0]);
      @(posedge clk); #1;
      if (s == stall - 1) rr = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rr = 1'b0;
    @(negedge clk);
    chk("post_valid", vld, 0);
    chk("post_ready", rdy, 1);
  endtask
  task automatic b2b(input logic [11:0] a);
    int t [3];
    int n, k;
    for (int i = 0; i < 3; i++) push(1'b0, 3'b010, a, 32'h0);
    @(posedge clk); #1;
    {we, f3, addr, rv, rr} = {1'b0, 3'b010, a, 1'b1, 1'b1};
    n = 0;
    k = 0;
    while (n < 3 && k < 100) begin
      @(negedge clk);
      if (rdy) begin
        t[n] = cyc;
        n++;
      end
      k++;
    end
    @(posedge clk); #1;
    rv = 1'b0;
    chk("b2b_count", n, 3);
    chk("b2b_gap0", t[1] - t[0], sel ? 6 : 3);
    chk("b2b_gap1", t[2] - t[1], sel ? 6 : 3);
    k = 0;
    while (q_exp.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_drain", q_exp.size(), 0);
    @(posedge clk); #1;
    rr = 1'b0;
  endtask
  task automatic drop_store(input logic [11:0] a, input logic [31:0] d, input int gap);
    int k;
    @(posedge clk); #1;
    {we, f3, addr, wd, rv} = {1'b1, 3'b010, a, d, 1'b1};
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (rdy) break;
      k++;
    end
    chk("drop_accept", k < 20, 1);
    @(posedge clk); #1;
    rv = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("drop_ready", rdy, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("drop_valid", vld, 0);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready1", i1.req_ready, 1);
    chk("rst_valid1", i1.rsp_valid, 0);
    chk("rst_rdata1", i1.rsp_rdata, 0);
    chk("rst_err1", i1.rsp_err, 0);
    chk("rst_ready4", i4.req_ready, 1);
    chk("rst_valid4", i4.rsp_valid, 0);
    chk("rst_rdata4", i4.rsp_rdata, 0);
    chk("rst_err4", i4.rsp_err, 0);
    sel = 1'b0;
    xact(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 0);
    xact(1'b0, 3'b010, 12'h010, 32'h0, 0);
    xact(1'b1, 3'b010, 12'hFFC, 32'h12345678, 0);
    xact(1'b1, 3'b010, 12'h000, 32'hA5A5A5A5, 1);
    xact(1'b0, 3'b010, 12'hFFC, 32'h0, 0);
    xact(1'b0, 3'b010, 12'h000, 32'h0, 2);
`ifdef DMEM_ALIGN_CHECK_EN
    xact(1'b1, 3'b010, 12'h012, 32'h11111111, 0);
    xact(1'b0, 3'b010, 12'h010, 32'h0, 0);
    xact(1'b0, 3'b000, 12'h010, 32'h0, 0);
    xact(1'b0, 3'b010, 12'h011, 32'h0, 0);
`else
    xact(1'b1, 3'b010, 12'h013, 32'h55AA33CC, 0);
    xact(1'b0, 3'b010, 12'h010, 32'h0, 0);
    xact(1'b0, 3'b000, 12'h012, 32'h0, 0);
`endif
    b2b(12'h010);
    xact(1'b1, 3'b010, 12'h040, 32'h0BADF00D, 0);
    drop_store(12'h040, 32'hFFFFFFFF, 0);
    xact(1'b0, 3'b010, 12'h040, 32'h0, 0);
    sel = 1'b1;
    xact(1'b1, 3'b010, 12'h010, 32'hCAFEF00D, 0);
    xact(1'b0, 3'b010, 12'h010, 32'h0, 3);
    b2b(12'h010);
    xact(1'b1, 3'b010, 12'h020, 32'h13579BDF, 0);
    drop_store(12'h020, 32'h2468ACE0, 2);
    xact(1'b0, 3'b010, 12'h020, 32'h0, 0);
    chk("sb_left", q_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
